// File: rtl/fb_dbuf.sv
// Double-buffered framebuffer: the CPU and the clear engine fill the back bank, video scans the front bank.
// Banks swap at vblank, and only once a flip has been requested and no clear is running.
module fb_dbuf #(
  parameter int FB_W     = 320,
  parameter int FB_H     = 240,
  parameter int SCALE_SH = 1,
  parameter int CW       = 12,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              clear_req,
  input  logic [CW-1:0]     clear_color,
  input  logic              flip_req,
  input  logic              frame_start,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              active,
  output logic [CW-1:0]     pix_color,
  output logic              pix_valid,
  output logic              busy,
  output logic              flip_pending,
  output logic              flip_done,
  output logic              front_sel
);

  localparam int                DEPTH   = FB_W * FB_H;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [10:0]       FB_W_L  = 11'(FB_W);
  localparam logic [10:0]       FB_H_L  = 11'(FB_H);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [CW-1:0]     clr_color;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CW-1:0]     wr_data;

  logic [CW-1:0] bank0 [DEPTH];
  logic [CW-1:0] bank1 [DEPTH];

  logic [9:0]        fx, fy;
  logic [19:0]       lin;
  logic              in_range;
  logic [ADDR_W-1:0] s1_addr;
  logic              s1_in, s1_active, s1_sel;

  logic unused_wdata;
  assign unused_wdata = ^cpu_wdata[31:CW];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear_req) state_next = CLEAR;
      CLEAR:   if (clr_cnt == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      clr_color <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && clear_req) begin
        clr_cnt   <= '0;
        clr_color <= clear_color;
      end else if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  assign busy = (state == CLEAR);

  // The clear engine owns the single write port while busy; CPU writes are dropped then.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cpu_addr;
    wr_data = cpu_wdata[CW-1:0];
    if (!reset) begin
      if (busy) begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        wr_data = clr_color;
      end else if (cpu_we && ({1'b0, cpu_addr} < DEPTH_L)) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (front_sel) bank0[wr_addr] <= wr_data;
      else           bank1[wr_addr] <= wr_data;
    end
  end

  // A flip needs a request seen on an earlier edge, so same-cycle flip_req only arms it.
  always_ff @(posedge clk) begin
    if (reset) begin
      front_sel    <= 1'b0;
      flip_pending <= 1'b0;
      flip_done    <= 1'b0;
    end else begin
      flip_done <= 1'b0;
      if (frame_start && flip_pending && !busy) begin
        front_sel    <= ~front_sel;
        flip_pending <= 1'b0;
        flip_done    <= 1'b1;
      end else if (flip_req) begin
        flip_pending <= 1'b1;
      end
    end
  end

  assign fx       = pixel_x >> SCALE_SH;
  assign fy       = pixel_y >> SCALE_SH;
  assign lin      = 20'(fy) * 20'(FB_W) + 20'(fx);
  assign in_range = ({1'b0, fx} < FB_W_L) && ({1'b0, fy} < FB_H_L);

  // The bank is chosen with front_sel as seen in stage 1, so a flip never tears a read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_addr   <= '0;
      s1_in     <= 1'b0;
      s1_active <= 1'b0;
      s1_sel    <= 1'b0;
      pix_color <= '0;
      pix_valid <= 1'b0;
    end else begin
      s1_addr   <= in_range ? ADDR_W'(lin) : '0;
      s1_in     <= in_range;
      s1_active <= active;
      s1_sel    <= front_sel;
      pix_color <= (s1_active && s1_in) ? (s1_sel ? bank1[s1_addr] : bank0[s1_addr]) : '0;
      pix_valid <= s1_active;
    end
  end

endmodule

// File: tb/tb_fb_dbuf.sv
// Directed bench for fb_dbuf: pixel reads go through a scoreboard queue checked by a monitor,
// control/status outputs are checked directly after each clock edge.
module tb_fb_dbuf;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [16:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        clear_req;
  logic [11:0] clear_color;
  logic        flip_req;
  logic        frame_start;
  logic [9:0]  pixel_x, pixel_y;
  logic        active;
  logic [11:0] pix_color;
  logic        pix_valid, busy, flip_pending, flip_done, front_sel;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [11:0] color;
    string       name;
  } exp_t;

  exp_t sbq[$];

  fb_dbuf dut (
    .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .clear_req(clear_req), .clear_color(clear_color), .flip_req(flip_req),
    .frame_start(frame_start), .pixel_x(pixel_x), .pixel_y(pixel_y), .active(active),
    .pix_color(pix_color), .pix_valid(pix_valid), .busy(busy), .flip_pending(flip_pending),
    .flip_done(flip_done), .front_sel(front_sel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every valid pixel must match the oldest outstanding expectation, both in colour and arrival cycle.
  always @(negedge clk) begin
    if (pix_valid === 1'b1) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_pixel actual=0x%0h required=no output", pix_color);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (pix_color !== e.color || cyc != e.cyc) begin
          bad++;
          $display("[TB] FAIL %s actual=0x%0h@%0d required=0x%0h@%0d",
                   e.name, pix_color, cyc, e.color, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Drives one active pixel for the coming edge and records what should emerge two cycles later.
  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y,
                               input logic [11:0] color, input string name);
    exp_t e;
    pixel_x = x;
    pixel_y = y;
    active  = 1'b1;
    e.cyc   = cyc + 2;
    e.color = color;
    e.name  = name;
    sbq.push_back(e);
  endtask

  task automatic readPixel(input logic [9:0] x, input logic [9:0] y,
                           input logic [11:0] color, input string name);
    applyStimulus(x, y, color, name);
    tick();
    active = 1'b0;
    tick();
    tick();
  endtask

  task automatic writeWord(input logic [16:0] addr, input logic [31:0] data);
    cpu_we    = 1'b1;
    cpu_addr  = addr;
    cpu_wdata = data;
    tick();
    cpu_we = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    clear_req = 1'b0; clear_color = '0; flip_req = 1'b0; frame_start = 1'b0;
    pixel_x = '0; pixel_y = '0; active = 1'b0;

    tick(); tick(); tick();
    checkOutput("rst_pix_color", 32'(pix_color), 32'h0);
    checkOutput("rst_pix_valid", 32'(pix_valid), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_flip_pending", 32'(flip_pending), 32'h0);
    checkOutput("rst_flip_done", 32'(flip_done), 32'h0);
    checkOutput("rst_front_sel", 32'(front_sel), 32'h0);
    reset = 1'b0;
    tick();

    $display("[TB] basic write and flip");
    writeWord(17'd5, 32'h0000_0ABC);
    flip_req = 1'b1; tick(); flip_req = 1'b0;
    checkOutput("pending_after_req", 32'(flip_pending), 32'h1);
    checkOutput("no_flip_before_vblank", 32'(front_sel), 32'h0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    checkOutput("flip1_front_sel", 32'(front_sel), 32'h1);
    checkOutput("flip1_done", 32'(flip_done), 32'h1);
    checkOutput("flip1_pending_clr", 32'(flip_pending), 32'h0);
    tick();
    checkOutput("flip1_done_pulse", 32'(flip_done), 32'h0);
    readPixel(10'd10, 10'd0, 12'hABC, "pix_10_0");

    $display("[TB] out-of-range access");
    writeWord(17'd76800, 32'h0000_0123);
    readPixel(10'd640, 10'd0, 12'h000, "pix_x640");
    readPixel(10'd0, 10'd480, 12'h000, "pix_y480");
    readPixel(10'd1023, 10'd1023, 12'h000, "pix_max");

    $display("[TB] clear with deferred flip");
    clear_color = 12'h0F0;
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    n = 0;
    while (busy && n < 80000) begin
      cpu_we      = (n == 3);
      cpu_addr    = 17'd0;
      cpu_wdata   = 32'h0000_000F;
      flip_req    = (n == 10);
      frame_start = (n == 12);
      clear_req   = (n == 20);
      clear_color = (n == 20) ? 12'h555 : 12'h0F0;
      if (n == 14) begin
        checkOutput("busy_flip_deferred", 32'(front_sel), 32'h1);
        checkOutput("busy_pending_kept", 32'(flip_pending), 32'h1);
        checkOutput("busy_no_done", 32'(flip_done), 32'h0);
      end
      n++;
      tick();
    end
    cpu_we = 1'b0; flip_req = 1'b0; frame_start = 1'b0; clear_req = 1'b0;
    checkOutput("busy_cycles", 32'(n), 32'd76800);
    checkOutput("pending_after_clear", 32'(flip_pending), 32'h1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    checkOutput("flip2_front_sel", 32'(front_sel), 32'h0);
    checkOutput("flip2_done", 32'(flip_done), 32'h1);
    tick();
    checkOutput("flip2_done_pulse", 32'(flip_done), 32'h0);
    readPixel(10'd0, 10'd0, 12'h0F0, "clr_0_0");
    readPixel(10'd639, 10'd479, 12'h0F0, "clr_639_479");
    readPixel(10'd320, 10'd240, 12'h0F0, "clr_320_240");
    readPixel(10'd10, 10'd0, 12'h0F0, "clr_10_0");

    $display("[TB] same-cycle flip request");
    flip_req = 1'b1; frame_start = 1'b1; tick(); flip_req = 1'b0; frame_start = 1'b0;
    checkOutput("same_cycle_no_flip", 32'(front_sel), 32'h0);
    checkOutput("same_cycle_pending", 32'(flip_pending), 32'h1);
    checkOutput("same_cycle_no_done", 32'(flip_done), 32'h0);
    tick();
    frame_start = 1'b1;
    applyStimulus(10'd10, 10'd0, 12'h0F0, "read_on_flip_edge");
    tick();
    frame_start = 1'b0;
    active = 1'b0;
    checkOutput("flip3_front_sel", 32'(front_sel), 32'h1);
    checkOutput("flip3_done", 32'(flip_done), 32'h1);
    tick(); tick();
    readPixel(10'd10, 10'd0, 12'hABC, "after_flip3_10_0");

    $display("[TB] reset during clear");
    clear_color = 12'h00A;
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    checkOutput("busy_before_abort", 32'(busy), 32'h1);
    reset = 1'b1; tick(); reset = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_front_sel", 32'(front_sel), 32'h0);
    clear_color = 12'h00B;
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    checkOutput("reclear_busy", 32'(busy), 32'h1);
    reset = 1'b1; tick(); reset = 1'b0;
    checkOutput("reabort_busy", 32'(busy), 32'h0);
    tick();
    readPixel(10'd10, 10'd0, 12'h00A, "partial_clear_5");
    readPixel(10'd200, 10'd0, 12'h0F0, "untouched_100");

    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain actual=%0d pending required=0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_dbuf.md
FB_DBUF -- requirements
Module: fb_dbuf

Interface
REQ-001 Parameter FB_W, default 320, framebuffer width in pixels.
REQ-002 Parameter FB_H, default 240, framebuffer height in pixels.
REQ-003 Parameter SCALE_SH, default 1, upscale shift: each stored pixel covers 2^SCALE_SH by 2^SCALE_SH screen pixels; legal values are 0, 1 and 2.
REQ-004 Parameter CW, default 12, stored colour width ({R,G,B} at 4 bits each at the default).
REQ-005 Parameter ADDR_W, default 17, CPU pixel address width; it SHALL satisfy 2^ADDR_W >= FB_W*FB_H.
REQ-006 clk  in  1  single clock for all logic; the one clock of the block.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 cpu_we  in  1  CPU pixel write strobe.
REQ-009 cpu_addr  in  ADDR_W  linear pixel index (y*FB_W+x) into the back bank.
REQ-010 cpu_wdata  in  32  write data; only bits [CW-1:0] are used.
REQ-011 clear_req  in  1  one-cycle pulse that starts a fill of the back bank.
REQ-012 clear_color  in  CW  fill colour, sampled on the clear_req cycle.
REQ-013 flip_req  in  1  one-cycle pulse requesting a front/back bank swap.
REQ-014 frame_start  in  1  one-cycle pulse from the timing generator at vblank start.
REQ-015 pixel_x, pixel_y  in  10 each  screen coordinate being scanned.
REQ-016 active  in  1  visible-area flag for pixel_x/pixel_y.
REQ-017 pix_color  out  CW  pixel colour for the screen.
REQ-018 pix_valid  out  1  active delayed to align with pix_color.
REQ-019 busy  out  1  high while the clear engine runs.
REQ-020 flip_pending  out  1  a flip has been requested and not yet taken.
REQ-021 flip_done  out  1  one-cycle pulse on the cycle the flip takes effect.
REQ-022 front_sel  out  1  index of the bank currently displayed.

Function
REQ-023 Storage SHALL be two banks of FB_W*FB_H x CW: front bank = front_sel, back bank = !front_sel.
REQ-024 A CPU write is accepted when cpu_we=1, cpu_addr < FB_W*FB_H and busy=0; it writes cpu_wdata[CW-1:0] to back[cpu_addr] on that edge.
- An out-of-range address SHALL be ignored.
- A write while busy=1 SHALL be dropped.
REQ-025 Clear FSM SHALL have two states, IDLE and CLEAR.
- IDLE->CLEAR on clear_req; latch clear_color; set counter to 0.
- In CLEAR, write the latched colour to back[counter] and increment counter, one address per cycle.
- CLEAR->IDLE after the write to address FB_W*FB_H-1.
- busy = (state == CLEAR), so busy is high for exactly FB_W*FB_H cycles.
- clear_req while busy SHALL be ignored.
REQ-026 flip_req SHALL set flip_pending on the next edge.
REQ-027 A flip SHALL occur on the first frame_start edge with flip_pending=1 and busy=0.
- On that edge front_sel toggles and flip_pending clears; flip_done is high in the following cycle only.
- If busy=1 at frame_start, the flip is deferred to a later frame_start.
REQ-028 flip_req in the same cycle as frame_start SHALL only set pending; that frame_start does not flip.
REQ-029 flip_req while already pending has no additional effect.
REQ-030 Video read SHALL be a 2-stage pipeline.
- Stage 1 registers fx = pixel_x>>SCALE_SH, fy = pixel_y>>SCALE_SH, addr = fy*FB_W+fx, an in-range flag, active, and front_sel.
- Stage 2 registers the RAM data.
- pix_color and pix_valid therefore appear exactly 2 cycles after the inputs.
REQ-031 pix_color SHALL be 0 whenever the delayed active is 0 or fx >= FB_W or fy >= FB_H.
REQ-032 Bank selection for a read SHALL use front_sel as captured in stage 1.

Reset
REQ-033 While reset=1, on each edge the block SHALL go to: pix_color=0, pix_valid=0, busy=0, flip_pending=0, flip_done=0, front_sel=0, FSM=IDLE, all pipeline registers cleared.
REQ-034 Reset mid-clear SHALL abort the fill; bank contents are not reset; busy reads 0 on the cycle after the reset edge.

Verification
REQ-035 After reset: write addr 5 = 0x00000ABC, pulse flip_req, pulse frame_start -> front_sel=1 and flip_done=1 for one cycle; then pixel_x=10, pixel_y=0, active=1 -> pix_color=0xABC, pix_valid=1 two cycles later.
REQ-036 clear_req with clear_color=0x0F0 -> busy high for exactly 76800 cycles; a CPU write to addr 0 during busy is dropped; after a flip, sampled pixels (0,0), (639,479) and (320,240) read 0x0F0.
REQ-037 flip_req then frame_start while busy=1 -> no toggle and flip_pending stays 1; next frame_start after busy falls -> toggle plus flip_done pulse.
REQ-038 flip_req and frame_start in the same cycle -> no flip and flip_pending=1; the next frame_start flips.
REQ-039 cpu_addr=76800 write -> no bank location changes; pixel_x=640 with active=1 -> pix_color=0 and pix_valid=1.
REQ-040 Reset asserted 100 cycles into a clear -> busy=0 next cycle; a new clear_req is accepted immediately afterwards.
